// File: rtl/uart_boot_sequencer.sv
// UART boot loader: receives a framed program image, writes it word-by-word into imem,
// verifies an additive checksum, replies ACK/NAK and then releases the CPU.
module uart_boot_sequencer #(
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter int          MAX_WORDS      = 1024,
    parameter logic [31:0] IMEM_BASE      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 500000,
    parameter int          RST_CYCLES     = 16
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    output logic        imem_WE,
    output logic [31:0] imem_A,
    output logic [31:0] imem_WD,
    output logic        cpu_stall,
    output logic        cpu_reset,
    output logic        prog_mode,
    output logic        boot_done,
    output logic        boot_error
);

    // Handshakes: rx_valid is a one-cycle strobe with no backpressure; a response
    // byte is transferred on the cycle where tx_valid && tx_ready, and tx_valid/tx_byte
    // stay constant until then.

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RST_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, CSUM, RESP, RELEASE
    } state_t;

    state_t             state, state_next;
    logic [7:0]         n_lo;
    logic [15:0]        n_words;
    logic [15:0]        word_idx;
    logic [1:0]         byte_idx;
    logic [23:0]        word_buf;
    logic [7:0]         csum;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [RST_W-1:0]   rst_cnt;

    logic               frame_start;
    logic               in_frame;
    logic               timeout;
    logic               tx_done;
    logic               rst_last;
    logic               resp_load;
    logic [7:0]         resp_code;
    logic [15:0]        len_rx;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        resp_load   = 1'b0;
        resp_code   = NAK;
        len_rx      = {rx_byte, n_lo};
        frame_start = (state == IDLE) && rx_valid && (rx_byte == MAGIC);
        in_frame    = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
        timeout     = in_frame && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
        tx_done     = tx_valid && tx_ready;
        rst_last    = (rst_cnt == RST_W'(RST_CYCLES - 1));
        case (state)
            IDLE:    if (frame_start) state_next = LEN0;
            LEN0:    if (rx_valid) state_next = LEN1;
            LEN1: begin
                if (rx_valid) begin
                    if (len_rx > 16'(MAX_WORDS)) begin
                        state_next = RESP;
                        resp_load  = 1'b1;
                    end else if (len_rx == 16'd0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_valid && byte_idx == 2'd3 && word_idx == n_words - 16'd1)
                    state_next = CSUM;
            end
            CSUM: begin
                if (rx_valid) begin
                    state_next = RESP;
                    resp_load  = 1'b1;
                    resp_code  = (rx_byte == csum) ? ACK : NAK;
                end
            end
            RESP:    if (tx_done) state_next = (tx_byte == ACK) ? RELEASE : IDLE;
            RELEASE: if (rst_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Timeout only fires on an idle cycle, so it never competes with a byte.
        if (timeout) begin
            state_next = RESP;
            resp_load  = 1'b1;
            resp_code  = NAK;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid   <= 1'b0;
            tx_byte    <= 8'h00;
            imem_WE    <= 1'b0;
            imem_A     <= 32'h0;
            imem_WD    <= 32'h0;
            cpu_stall  <= 1'b0;
            cpu_reset  <= 1'b0;
            prog_mode  <= 1'b0;
            boot_done  <= 1'b0;
            boot_error <= 1'b0;
            n_lo       <= 8'h00;
            n_words    <= 16'h0;
            word_idx   <= 16'h0;
            byte_idx   <= 2'd0;
            word_buf   <= 24'h0;
            csum       <= 8'h00;
            tmo_cnt    <= '0;
            rst_cnt    <= '0;
        end else begin
            imem_WE <= 1'b0;
            if (!in_frame || rx_valid) tmo_cnt <= '0;
            else                       tmo_cnt <= tmo_cnt + TMO_W'(1);

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        prog_mode  <= 1'b1;
                        cpu_stall  <= 1'b1;
                        boot_done  <= 1'b0;
                        boot_error <= 1'b0;
                        csum       <= 8'h00;
                        byte_idx   <= 2'd0;
                        word_idx   <= 16'h0;
                    end
                end
                LEN0: if (rx_valid) n_lo <= rx_byte;
                LEN1: if (rx_valid) n_words <= len_rx;
                DATA: begin
                    if (rx_valid) begin
                        csum     <= csum + rx_byte;
                        byte_idx <= byte_idx + 2'd1;
                        // Bytes enter at the top so the first byte ends up in bits 7:0.
                        word_buf <= {rx_byte, word_buf[23:8]};
                        if (byte_idx == 2'd3) begin
                            imem_WE  <= 1'b1;
                            imem_A   <= IMEM_BASE + {14'd0, word_idx, 2'b00};
                            imem_WD  <= {rx_byte, word_buf};
                            word_idx <= word_idx + 16'd1;
                        end
                    end
                end
                RESP: begin
                    if (tx_done) begin
                        tx_valid  <= 1'b0;
                        prog_mode <= 1'b0;
                        if (tx_byte == ACK) begin
                            boot_done <= 1'b1;
                            cpu_reset <= 1'b1;
                            rst_cnt   <= '0;
                        end else begin
                            boot_error <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    rst_cnt <= rst_cnt + RST_W'(1);
                    if (rst_last) begin
                        cpu_reset <= 1'b0;
                        cpu_stall <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (resp_load) begin
                tx_valid <= 1'b1;
                tx_byte  <= resp_code;
            end
        end
    end

endmodule
